// File: rtl/if_inst_queue.sv
// if_inst_queue: DEPTH-entry {PC, Inst} FIFO between fetch and decode.
// Flush empties the queue; misaligned fetch PCs are flagged at the head.
module if_inst_queue #(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [63:0]   in_bus,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [63:0]   out_bus,
  output logic          out_adef,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [PW-1:0] PONE = PW'(1);

  logic [63:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic          empty;

  assign empty     = (count == '0);
  assign in_ready  = (count != FULL) & ~flush;
  assign out_valid = ~empty & ~flush;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Head is forced to zero when empty so stale storage never leaks out.
  assign out_bus  = empty ? 64'h0 : mem[rd_ptr];
  assign out_adef = out_valid & (out_bus[33:32] != 2'b00);

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem[wr_ptr] <= in_bus;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PONE;
      end
      unique case ({push, pop})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_if_inst_queue.sv
// tb_if_inst_queue: vector table plus queue scoreboard
// for the fetch-to-decode instruction FIFO.
module tb_if_inst_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_bus;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_bus;
  logic        out_adef;
  logic [2:0]  count;

  if_inst_queue #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_bus(in_bus),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_bus(out_bus), .out_adef(out_adef), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        fl;
    logic        iv;
    logic        ordy;
    logic [31:0] pc;
    logic [2:0]  ec;
    logic        eov;
    logic        eir;
  } vec_t;

  vec_t        tbl[$];
  logic [63:0] sb[$];
  int          n_chk  = 0;
  int          n_fail = 0;

  function automatic vec_t mk(logic r, logic f, logic iv, logic od,
                              logic [31:0] pc, logic [2:0] ec,
                              logic ov, logic ir);
    vec_t v;
    v.rst = r; v.fl = f; v.iv = iv; v.ordy = od; v.pc = pc;
    v.ec = ec; v.eov = ov; v.eir = ir;
    return v;
  endfunction

  function automatic logic [63:0] mkbus(logic [31:0] pc);
    return {pc, 32'h0280_0000 | {16'h0, pc[15:0]}};
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input vec_t v);
    logic [63:0] head;
    logic [63:0] bus;
    logic [63:0] got;
    logic        pu;
    logic        po;
    @(negedge clk);
    bus       = mkbus(v.pc);
    reset     = v.rst;
    flush     = v.fl;
    in_valid  = v.iv;
    out_ready = v.ordy;
    in_bus    = bus;
    #1;
    chk("count", 64'(count), 64'(v.ec));
    chk("out_valid", 64'(out_valid), 64'(v.eov));
    chk("in_ready", 64'(in_ready), 64'(v.eir));
    head = (sb.size() != 0) ? sb[0] : 64'h0;
    chk("out_bus", out_bus, head);
    chk("out_adef", 64'(out_adef),
        64'((sb.size() != 0) && !v.fl && (head[33:32] != 2'b00)));
    pu = v.iv && (sb.size() != 4) && !v.fl;
    po = (sb.size() != 0) && !v.fl && v.ordy;
    got = out_bus;
    @(posedge clk);
    if (v.rst || v.fl) begin
      sb.delete();
    end else begin
      if (po) chk("pop_order", got, sb.pop_front());
      if (pu) sb.push_back(bus);
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
    out_ready = 1'b0; in_bus = 64'h0;
    repeat (2) @(posedge clk);

    // rst fl iv rdy pc ec ov ir
    tbl.push_back(mk(0,0,0,0,32'h0,        0,0,1));
    tbl.push_back(mk(0,0,1,0,32'h1C000000, 0,0,1));
    tbl.push_back(mk(0,0,0,0,32'h0,        1,1,1));
    tbl.push_back(mk(0,0,0,1,32'h0,        1,1,1));
    tbl.push_back(mk(0,0,1,0,32'h1C000000, 0,0,1));
    tbl.push_back(mk(0,0,1,0,32'h1C000004, 1,1,1));
    tbl.push_back(mk(0,0,1,0,32'h1C000008, 2,1,1));
    tbl.push_back(mk(0,0,1,0,32'h1C00000C, 3,1,1));
    tbl.push_back(mk(0,0,1,0,32'h1C000010, 4,1,0));
    tbl.push_back(mk(0,0,0,1,32'h0,        4,1,0));
    tbl.push_back(mk(0,0,0,1,32'h0,        3,1,1));
    tbl.push_back(mk(0,0,0,1,32'h0,        2,1,1));
    tbl.push_back(mk(0,0,0,1,32'h0,        1,1,1));
    tbl.push_back(mk(0,0,0,1,32'h0,        0,0,1));
    tbl.push_back(mk(0,0,1,0,32'h1C000010, 0,0,1));
    tbl.push_back(mk(0,0,1,0,32'h1C000014, 1,1,1));
    tbl.push_back(mk(0,0,1,0,32'h1C000018, 2,1,1));
    tbl.push_back(mk(0,1,1,1,32'h1C000020, 3,0,0));
    tbl.push_back(mk(0,0,1,0,32'h1C000100, 0,0,1));
    tbl.push_back(mk(0,0,0,1,32'h0,        1,1,1));
    tbl.push_back(mk(0,0,1,0,32'h1C000002, 0,0,1));
    tbl.push_back(mk(0,0,1,0,32'h1C000004, 1,1,1));
    tbl.push_back(mk(0,0,0,1,32'h0,        2,1,1));
    tbl.push_back(mk(0,0,0,1,32'h0,        1,1,1));
    tbl.push_back(mk(0,0,1,0,32'h1C000200, 0,0,1));
    tbl.push_back(mk(0,0,1,0,32'h1C000204, 1,1,1));
    tbl.push_back(mk(0,0,1,0,32'h1C000208, 2,1,1));
    tbl.push_back(mk(1,1,1,1,32'h1C00020C, 3,0,0));
    tbl.push_back(mk(0,0,0,0,32'h0,        0,0,1));
    tbl.push_back(mk(0,0,1,0,32'h1C000300, 0,0,1));
    tbl.push_back(mk(0,1,0,0,32'h0,        1,0,0));
    tbl.push_back(mk(0,1,1,1,32'h1C000304, 0,0,0));
    tbl.push_back(mk(0,0,1,0,32'h1C000308, 0,0,1));
    tbl.push_back(mk(0,0,0,1,32'h0,        1,1,1));

    foreach (tbl[i]) step(tbl[i]);

    // Steady state at occupancy 2: pointers wrap twice in 8 cycles.
    step(mk(0,0,1,0,32'h1C001000, 0,0,1));
    step(mk(0,0,1,0,32'h1C001004, 1,1,1));
    for (int k = 0; k < 8; k++) begin
      step(mk(0,0,1,1,32'h1C001008 + 32'(4*k), 2,1,1));
    end
    step(mk(0,0,0,1,32'h0, 2,1,1));
    step(mk(0,0,0,1,32'h0, 1,1,1));
    step(mk(0,0,0,1,32'h0, 0,0,1));

    // Mid-operation reset alone also drops everything.
    step(mk(0,0,1,0,32'h1C002000, 0,0,1));
    step(mk(0,0,1,0,32'h1C002001, 1,1,1));
    step(mk(1,0,0,0,32'h0,        2,1,1));
    step(mk(0,0,0,1,32'h0,        0,0,1));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
